// File: rtl/ranging_scheduler.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing, divider-free cm conversion,
// timeouts, fixed ping period and saturated distance output.
module ranging_scheduler #(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int PERIOD_CYCLES = 3000000,
  parameter int MAX_CM        = 400,
  parameter int DIST_W        = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              distance_valid,
  output logic              timeout,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int MAX_A = (TRIG_CYCLES > CYCLES_PER_CM) ? TRIG_CYCLES : CYCLES_PER_CM;
  localparam int MAX_B = (ECHO_TIMEOUT > PERIOD_CYCLES) ? ECHO_TIMEOUT : PERIOD_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CPC_LAST  = CNT_W'(CYCLES_PER_CM - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [DIST_W-1:0] CM_SAT    = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              echo_m, echo_s;
  logic [CNT_W-1:0]  period_q, period_d;
  // phase counts trig clocks in TRIG, wait clocks in WAIT_ECHO, echo clocks N in MEASURE
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]  sub_q, sub_d, sub_step;
  logic [DIST_W-1:0] cm_q, cm_d, cm_step;
  logic [DIST_W-1:0] dist_d;
  logic              trig_d, valid_d, timeout_d, busy_d;

  assign state = state_q;

  // One echo-high clock worth of cm accumulation.
  always_comb begin
    sub_step = sub_q + 1'b1;
    cm_step  = cm_q;
    if (sub_q == CPC_LAST) begin
      sub_step = '0;
      if (cm_q != CM_SAT) cm_step = cm_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    trig_d    = 1'b0;
    period_d  = period_q;
    phase_d   = phase_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    dist_d    = distance;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (state_q != IDLE) period_d = period_q + 1'b1;
    case (state_q)
      IDLE: begin
        period_d = '0;
        phase_d  = '0;
        if (enable || start) begin
          state_d = TRIG;
          trig_d  = 1'b1;
        end
      end
      TRIG: begin
        if (phase_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          phase_d = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else begin
          trig_d  = 1'b1;
          phase_d = phase_q + 1'b1;
        end
      end
      WAIT_ECHO: begin
        if (echo_s) begin
          state_d = MEASURE;
          phase_d = CNT_W'(1);
          sub_d   = sub_step;
          cm_d    = cm_step;
        end else if (phase_q == TO_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_d = HOLDOFF;
          dist_d  = cm_q;
          valid_d = 1'b1;
        end else if (phase_q == TO_LAST) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
          sub_d   = sub_step;
          cm_d    = cm_step;
        end
      end
      HOLDOFF: begin
        if (period_q == PER_LAST) begin
          period_d = '0;
          phase_d  = '0;
          if (enable) begin
            state_d = TRIG;
            trig_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      echo_m         <= 1'b0;
      echo_s         <= 1'b0;
      period_q       <= '0;
      phase_q        <= '0;
      sub_q          <= '0;
      cm_q           <= '0;
      trig           <= 1'b0;
      distance       <= '0;
      distance_valid <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      echo_m         <= echo;
      echo_s         <= echo_m;
      period_q       <= period_d;
      phase_q        <= phase_d;
      sub_q          <= sub_d;
      cm_q           <= cm_d;
      trig           <= trig_d;
      distance       <= dist_d;
      distance_valid <= valid_d;
      timeout        <= timeout_d;
      busy           <= busy_d;
    end
  end

endmodule
